filtro_coef_sequencer: RTL

//  Sequences the time-multiplexed MAC of the recursive (biquad) filter for one sample.

---
 rtl/filtro_coef_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/filtro_coef_sequencer.sv
// Sequencer for the time-multiplexed biquad MAC: latches the band once per sample,
// walks the coefficient taps, gates the MAC and produces history/valid strobes.
module filtro_coef_sequencer #(
  parameter int NUM_TAPS = 5,
  parameter int TAP_W    = 3,
  parameter int MAC_LAT  = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sample_tick_i,
  input  logic [1:0]       band_sel_i,
  input  logic             overrun_clr_i,
  output logic [1:0]       coef_sel_o,
  output logic [TAP_W-1:0] tap_idx_o,
  output logic             mac_en_o,
  output logic             mac_clr_o,
  output logic             hist_clr_o,
  output logic             hist_shift_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_TAP   = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(MAC_LAT - 1);
  localparam logic [TAP_W-1:0] TAP_MAX    = TAP_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {IDLE, FLUSH, MAC, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       coef_sel_q, coef_sel_d;
  logic             primed_q, primed_d;
  logic             overrun_q, overrun_d;
  logic [TAP_W-1:0] tap_idx_q, tap_idx_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;
  logic             hist_clr_q, hist_clr_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Outputs are decoded from the next state so that every port comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    coef_sel_d = coef_sel_q;
    primed_d   = primed_q;
    overrun_d  = overrun_q;

    if (overrun_clr_i) overrun_d = 1'b0;
    if (sample_tick_i && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_tick_i) begin
          coef_sel_d = band_sel_i;
          primed_d   = 1'b1;
          cnt_d      = '0;
          if (!primed_q || (band_sel_i != coef_sel_q)) state_d = FLUSH;
          else                                          state_d = MAC;
        end
      end
      FLUSH: begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        if (cnt_q == LAST_TAP) begin
          cnt_d   = '0;
          state_d = (MAC_LAT == 0) ? DONE : DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d     = (state_d != IDLE);
    hist_clr_d = (state_d == FLUSH);
    mac_en_d   = (state_d == MAC);
    mac_clr_d  = (state_d == MAC) && (cnt_d == '0);
    done_d     = (state_d == DONE);
    case (state_d)
      MAC:         tap_idx_d = cnt_d[TAP_W-1:0];
      DRAIN, DONE: tap_idx_d = TAP_MAX;
      default:     tap_idx_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      coef_sel_q <= 2'b00;
      primed_q   <= 1'b0;
      overrun_q  <= 1'b0;
      tap_idx_q  <= '0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      hist_clr_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      coef_sel_q <= coef_sel_d;
      primed_q   <= primed_d;
      overrun_q  <= overrun_d;
      tap_idx_q  <= tap_idx_d;
      mac_en_q   <= mac_en_d;
      mac_clr_q  <= mac_clr_d;
      hist_clr_q <= hist_clr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign coef_sel_o   = coef_sel_q;
  assign tap_idx_o    = tap_idx_q;
  assign mac_en_o     = mac_en_q;
  assign mac_clr_o    = mac_clr_q;
  assign hist_clr_o   = hist_clr_q;
  assign hist_shift_o = done_q;
  assign out_valid_o  = done_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule
